// File: rtl/serial_cmd_deserializer_pkg.sv
// Shared types for the shift-register command path: frame mode encoding and
// the deserializer FSM state encoding.
package shift_reg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_CLEAR = 2'b01,
    MODE_SHR   = 2'b10,
    MODE_SHL   = 2'b11
  } shift_mode_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    OUT  = 3'd4
  } deser_state_t;

endpackage

// File: rtl/serial_cmd_deserializer_if.sv
// Serial input stream plus parallel frame output of the command deserializer.
// master = stream producer / frame consumer side, slave = the deserializer.
interface serial_cmd_deserializer_if #(
  parameter int WIDTH = 8
);

  logic             in_bit;
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic [1:0]       out_mode;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;

  modport master (
    output in_bit, in_valid, in_sof, out_ready,
    input  in_ready, out_mode, out_data, out_valid, frame_err
  );

  modport slave (
    input  in_bit, in_valid, in_sof, out_ready,
    output in_ready, out_mode, out_data, out_valid, frame_err
  );

endinterface

// File: rtl/serial_cmd_deserializer.sv
// Collects a serial frame (2 mode bits + WIDTH data bits) and presents it with a
// valid/ready handshake. Define SERIAL_CMD_PARITY_EN to add a trailing even-parity bit.
module serial_cmd_deserializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_cmd_deserializer_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  deser_state_t      state_r;
  deser_state_t      next_state_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_next_s;
  logic [CW-1:0]     pos_s;
  logic [1:0]        mode_sh_r;
  logic [1:0]        mode_sh_next_s;
  logic [WIDTH-1:0]  data_sh_r;
  logic [WIDTH-1:0]  data_sh_next_s;
  shift_mode_t       out_mode_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              load_out_s;
  logic              in_ready_s;
  logic              accept_s;

`ifdef SERIAL_CMD_PARITY_EN
  logic              err_next_s;
  logic              frame_err_r;

  function automatic logic even_parity(input logic [1:0] mode, input logic [WIDTH-1:0] data);
    return ^{mode, data};
  endfunction
`endif

  assign in_ready_s = (state_r != OUT);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign pos_s      = MSB_FIRST ? (LAST - cnt_r) : cnt_r;

  // Next-state and shadow-register update; a start-of-frame bit restarts from any assembling state.
  always_comb begin
    next_state_s   = state_r;
    cnt_next_s     = cnt_r;
    mode_sh_next_s = mode_sh_r;
    data_sh_next_s = data_sh_r;
    load_out_s     = 1'b0;
`ifdef SERIAL_CMD_PARITY_EN
    err_next_s     = 1'b0;
`endif
    if (accept_s && bus.in_sof) begin
      mode_sh_next_s[1] = bus.in_bit;
      next_state_s      = HDR;
    end else begin
      case (state_r)
        IDLE: begin
          next_state_s = IDLE;
        end
        HDR: begin
          if (accept_s) begin
            mode_sh_next_s[0] = bus.in_bit;
            cnt_next_s        = {CW{1'b0}};
            next_state_s      = DATA;
          end else begin
            next_state_s = HDR;
          end
        end
        DATA: begin
          if (accept_s) begin
            data_sh_next_s[pos_s] = bus.in_bit;
            cnt_next_s            = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == LAST) begin
`ifdef SERIAL_CMD_PARITY_EN
              next_state_s = PAR;
`else
              next_state_s = OUT;
              load_out_s   = 1'b1;
`endif
            end else begin
              next_state_s = DATA;
            end
          end else begin
            next_state_s = DATA;
          end
        end
`ifdef SERIAL_CMD_PARITY_EN
        PAR: begin
          if (accept_s) begin
            if (bus.in_bit == even_parity(mode_sh_r, data_sh_r)) begin
              next_state_s = OUT;
              load_out_s   = 1'b1;
            end else begin
              next_state_s = IDLE;
              err_next_s   = 1'b1;
            end
          end else begin
            next_state_s = PAR;
          end
        end
`endif
        OUT: begin
          if (bus.out_ready) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = OUT;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // State, assembly shadows and output registers; outputs change only on entry to OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      mode_sh_r  <= 2'b00;
      data_sh_r  <= {WIDTH{1'b0}};
      out_mode_r <= MODE_LOAD;
      out_data_r <= {WIDTH{1'b0}};
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_next_s;
      mode_sh_r <= mode_sh_next_s;
      data_sh_r <= data_sh_next_s;
      if (load_out_s) begin
        out_mode_r <= shift_mode_t'(mode_sh_next_s);
        out_data_r <= data_sh_next_s;
      end
    end
  end

`ifdef SERIAL_CMD_PARITY_EN
  // One-cycle parity error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= err_next_s;
    end
  end

  assign bus.frame_err = frame_err_r;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == OUT);
  assign bus.out_mode  = out_mode_r;
  assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_serial_cmd_deserializer.sv
// Directed bench: one MSB-first and one LSB-first deserializer driven with
// hand-computed frames; parity cases run when SERIAL_CMD_PARITY_EN is defined.
module tb_serial_cmd_deserializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_cmd_deserializer_if #(.WIDTH(8)) a_if ();
  serial_cmd_deserializer_if #(.WIDTH(8)) b_if ();

  serial_cmd_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  serial_cmd_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one bit on the MSB-first DUT for a single cycle; returns just after the edge.
  task automatic drive_a(input logic b, input logic sof);
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.in_bit   = b;
    a_if.in_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic b, input logic sof);
    @(negedge clk);
    b_if.in_valid = 1'b1;
    b_if.in_bit   = b;
    b_if.in_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.in_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame_a(input logic [1:0] m, input logic [7:0] d);
    drive_a(m[1], 1'b1);
    drive_a(m[0], 1'b0);
    for (int i = 7; i >= 0; i--) drive_a(d[i], 1'b0);
`ifdef SERIAL_CMD_PARITY_EN
    drive_a(^{m, d}, 1'b0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_if.in_bit = 1'b0; a_if.in_valid = 1'b0; a_if.in_sof = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_bit = 1'b0; b_if.in_valid = 1'b0; b_if.in_sof = 1'b0; b_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  a_if.in_ready,  1);
    check_eq("rst_out_valid", a_if.out_valid, 0);
    check_eq("rst_out_mode",  a_if.out_mode,  0);
    check_eq("rst_out_data",  a_if.out_data,  0);
    check_eq("rst_frame_err", a_if.frame_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stray non-sof bits in IDLE are dropped, then 10/A5 with out_ready=1
    drive_a(1'b1, 1'b0);
    drive_a(1'b0, 1'b0);
    check_eq("idle_discard_valid", a_if.out_valid, 0);
    check_eq("idle_discard_ready", a_if.in_ready,  1);
    send_frame_a(2'b10, 8'hA5);
    check_eq("f1_valid",    a_if.out_valid, 1);
    check_eq("f1_mode",     a_if.out_mode,  2'b10);
    check_eq("f1_data",     a_if.out_data,  8'hA5);
    check_eq("f1_in_ready", a_if.in_ready,  0);
    idle_a();
    check_eq("f1_valid_drop", a_if.out_valid, 0);
    check_eq("f1_ready_back", a_if.in_ready,  1);
    check_eq("f1_data_held",  a_if.out_data,  8'hA5);

    // Back-pressure: same frame, consumer stalls 5 cycles while new bits are offered
    a_if.out_ready = 1'b0;
    send_frame_a(2'b10, 8'hA5);
    check_eq("bp_valid", a_if.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, (i == 0) ? 1'b1 : 1'b0);
      check_eq("bp_hold_valid", a_if.out_valid, 1);
      check_eq("bp_hold_ready", a_if.in_ready,  0);
      check_eq("bp_hold_data",  a_if.out_data,  8'hA5);
    end
    @(negedge clk);
    a_if.in_valid  = 1'b0;
    a_if.in_sof    = 1'b0;
    a_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release_valid", a_if.out_valid, 0);
    check_eq("bp_release_ready", a_if.in_ready,  1);
    check_eq("bp_release_mode",  a_if.out_mode,  2'b10);

    // Abort after 4 data bits of a 01 frame, then full 11/3C
    drive_a(1'b0, 1'b1);
    drive_a(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive_a(1'b1, 1'b0);
    check_eq("abort_no_valid", a_if.out_valid, 0);
    send_frame_a(2'b11, 8'h3C);
    check_eq("abort_valid", a_if.out_valid, 1);
    check_eq("abort_mode",  a_if.out_mode,  2'b11);
    check_eq("abort_data",  a_if.out_data,  8'h3C);
    idle_a();
    check_eq("abort_single", a_if.out_valid, 0);

    // LSB-first instance: mode 00, data bits 1,0,0,0,0,0,0,0
    drive_b(1'b0, 1'b1);
    drive_b(1'b0, 1'b0);
    drive_b(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive_b(1'b0, 1'b0);
`ifdef SERIAL_CMD_PARITY_EN
    drive_b(1'b1, 1'b0);
`endif
    check_eq("lsb_valid", b_if.out_valid, 1);
    check_eq("lsb_mode",  b_if.out_mode,  2'b00);
    check_eq("lsb_data",  b_if.out_data,  8'h01);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    b_if.in_sof   = 1'b0;

    // Reset mid-frame after 5 data bits, then 00/FF
    drive_a(1'b1, 1'b1);
    drive_a(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_a(1'b1, 1'b0);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", a_if.out_valid, 0);
    check_eq("mid_rst_data",  a_if.out_data,  0);
    check_eq("mid_rst_ready", a_if.in_ready,  1);
    @(negedge clk);
    rst = 1'b0;
    send_frame_a(2'b00, 8'hFF);
    check_eq("post_rst_valid", a_if.out_valid, 1);
    check_eq("post_rst_mode",  a_if.out_mode,  2'b00);
    check_eq("post_rst_data",  a_if.out_data,  8'hFF);
    idle_a();

`ifdef SERIAL_CMD_PARITY_EN
    // Mode 01, data 01: even parity over {mode,data} is 0, so a 1 is an error
    drive_a(1'b0, 1'b1);
    drive_a(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive_a(1'b0, 1'b0);
    drive_a(1'b1, 1'b0);
    drive_a(1'b1, 1'b0);
    check_eq("par_err_pulse", a_if.frame_err, 1);
    check_eq("par_err_valid", a_if.out_valid, 0);
    check_eq("par_err_data",  a_if.out_data,  8'hFF);
    idle_a();
    check_eq("par_err_clear", a_if.frame_err, 0);
    check_eq("par_err_novld", a_if.out_valid, 0);
    drive_a(1'b0, 1'b1);
    drive_a(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive_a(1'b0, 1'b0);
    drive_a(1'b1, 1'b0);
    drive_a(1'b0, 1'b0);
    check_eq("par_ok_valid", a_if.out_valid, 1);
    check_eq("par_ok_mode",  a_if.out_mode,  2'b01);
    check_eq("par_ok_data",  a_if.out_data,  8'h01);
    check_eq("par_ok_err",   a_if.frame_err, 0);
    idle_a();
`else
    check_eq("no_par_err", a_if.frame_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
